fp_addsub_round_stage: RTL

- Pipelined round-and-pack stage directly downstream of the FP add/sub normalize stage.
- Consumes a normalized 26-bit mantissa (hidden bit, fraction, guard, round), a sticky bit, a biased exponent and a sign.
- Applies IEEE754 round-to-nearest-even, handles mantissa carry-out and exponent overflow, and packs a single-precision word Z.
- Two register stages with a valid/ready handshake, so the add/sub datapath can stall.

---
 rtl/fp_addsub_round_stage.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/fp_addsub_round_stage.sv
`default_nettype none
// ============================================================================
// Module   : fp_addsub_round_stage
// Brief    : Two-stage round-and-pack for the FP add/sub datapath. It rounds
//            to nearest even, handles carry-out and exponent overflow, and
//            packs a binary32 word. Transfers use a valid/ready handshake.
//            Optional macro FPADDSUB_ROUND_MODES_EN adds the RM port
//            (RNE/RZ/RU/RD).
// Revision : 1.0 - initial release
// ============================================================================
module fp_addsub_round_stage #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [FRAC_W+2:0]         M,
    input  logic                      St,
    input  logic [EXP_W-1:0]          E,
    input  logic                      S,
    input  logic                      NaN_in,
`ifdef FPADDSUB_ROUND_MODES_EN
    input  logic [1:0]                RM,
`endif
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+FRAC_W:0]     Z,
    output logic                      Ovf,
    output logic                      Inx
);

    localparam logic [EXP_W+FRAC_W:0] c_QNAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
    localparam logic [EXP_W:0]        c_EXP_OVF = {1'b0, {EXP_W{1'b1}}};
    localparam logic [EXP_W-1:0]      c_EXP_INF = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0]      c_EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};

`ifdef FPADDSUB_ROUND_MODES_EN
    localparam logic [1:0] c_RM_RZ = 2'b01;
    localparam logic [1:0] c_RM_RU = 2'b10;
    localparam logic [1:0] c_RM_RD = 2'b11;
`endif

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_valid_q;
    logic s2_valid_q;
    logic s1_adv;
    logic s2_adv;

    assign s2_adv    = !s2_valid_q || out_ready;
    assign s1_adv    = !s1_valid_q || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_q;

    // ------------------------------------------------------------------
    // Stage 1: rounding increment
    // ------------------------------------------------------------------
    logic              w_lsb;
    logic              w_g;
    logic              w_rest;
    logic              w_inx1;
    logic              w_inc;
    logic              w_zero;
    logic [FRAC_W+1:0] w_sum;

    assign w_lsb  = M[2];
    assign w_g    = M[1];
    assign w_rest = M[0] | St;
    assign w_inx1 = w_g | M[0] | St;
    assign w_zero = (M == '0) && !St;
    assign w_sum  = {1'b0, M[FRAC_W+2:2]} + {{(FRAC_W+1){1'b0}}, w_inc};

    always_comb begin
        w_inc = w_g & (w_rest | w_lsb);
`ifdef FPADDSUB_ROUND_MODES_EN
        case (RM)
            c_RM_RZ: w_inc = 1'b0;
            c_RM_RU: w_inc = w_inx1 & !S;
            c_RM_RD: w_inc = w_inx1 & S;
            default: w_inc = w_g & (w_rest | w_lsb);
        endcase
`endif
    end

    logic [FRAC_W+1:0] s1_sum_q;
    logic              s1_inc_q;
    logic              s1_inx_q;
    logic              s1_zero_q;
    logic [EXP_W-1:0]  s1_e_q;
    logic              s1_s_q;
    logic              s1_nan_q;
`ifdef FPADDSUB_ROUND_MODES_EN
    logic [1:0]        s1_rm_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_inc_q   <= 1'b0;
            s1_inx_q   <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_e_q     <= '0;
            s1_s_q     <= 1'b0;
            s1_nan_q   <= 1'b0;
`ifdef FPADDSUB_ROUND_MODES_EN
            s1_rm_q    <= 2'b00;
`endif
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sum_q  <= w_sum;
                s1_inc_q  <= w_inc;
                s1_inx_q  <= w_inx1;
                s1_zero_q <= w_zero;
                s1_e_q    <= E;
                s1_s_q    <= S;
                s1_nan_q  <= NaN_in;
`ifdef FPADDSUB_ROUND_MODES_EN
                s1_rm_q   <= RM;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: special cases, carry renormalisation, overflow, pack
    // ------------------------------------------------------------------
    logic                  w_carry;
    logic [EXP_W:0]        w_exp_ext;
    logic [FRAC_W-1:0]     w_frac;
    logic                  w_exp_ovf;
    logic                  w_sat_max;
    logic [EXP_W+FRAC_W:0] z_d;
    logic                  ovf_d;
    logic                  inx_d;

    assign w_carry   = s1_sum_q[FRAC_W+1];
    assign w_exp_ext = {1'b0, s1_e_q} + {{EXP_W{1'b0}}, w_carry};
    // On carry the sum is exactly 10.00..0, so the shifted field is zero.
    assign w_frac    = w_carry ? s1_sum_q[FRAC_W:1] : s1_sum_q[FRAC_W-1:0];
    assign w_exp_ovf = (w_exp_ext >= c_EXP_OVF);

`ifdef FPADDSUB_ROUND_MODES_EN
    // Directed modes rounding towards zero saturate at max finite.
    assign w_sat_max = (s1_rm_q == c_RM_RZ) ||
                       ((s1_rm_q == c_RM_RU) &&  s1_s_q) ||
                       ((s1_rm_q == c_RM_RD) && !s1_s_q);
`else
    assign w_sat_max = 1'b0;
`endif

    always_comb begin
        z_d   = {s1_s_q, w_exp_ext[EXP_W-1:0], w_frac};
        ovf_d = 1'b0;
        inx_d = s1_inx_q;
        if (s1_nan_q) begin
            z_d   = c_QNAN;
            inx_d = 1'b0;
        end else if (s1_zero_q) begin
            z_d   = {s1_s_q, {(EXP_W+FRAC_W){1'b0}}};
            inx_d = 1'b0;
        end else if (s1_e_q == '0) begin
            z_d   = {s1_s_q, {(EXP_W+FRAC_W){1'b0}}};
            inx_d = 1'b1;
        end else if (w_exp_ovf) begin
            ovf_d = 1'b1;
            inx_d = 1'b1;
            if (w_sat_max) begin
                z_d = {s1_s_q, c_EXP_MAXF, {FRAC_W{1'b1}}};
            end else begin
                z_d = {s1_s_q, c_EXP_INF, {FRAC_W{1'b0}}};
            end
        end
    end

    logic [EXP_W+FRAC_W:0] z_q;
    logic                  ovf_q;
    logic                  inx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            z_q        <= '0;
            ovf_q      <= 1'b0;
            inx_q      <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                z_q   <= z_d;
                ovf_q <= ovf_d;
                inx_q <= inx_d;
            end
        end
    end

    assign Z   = z_q;
    assign Ovf = ovf_q;
    assign Inx = inx_q;

    // The increment is folded into the registered sum; only kept for debug.
    logic w_unused;
    assign w_unused = s1_inc_q;

endmodule
`default_nettype wire
